// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared types, format codes and load-formatting helper for the
//               write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam logic [2:0] FMT_LB   = 3'b000;
    localparam logic [2:0] FMT_LH   = 3'b001;
    localparam logic [2:0] FMT_LW   = 3'b010;
    localparam logic [2:0] FMT_LBU  = 3'b100;
    localparam logic [2:0] FMT_LHU  = 3'b101;
    localparam logic [2:0] FMT_PASS = 3'b111;

    // Register address is carried at a fixed maximum width; users slice it.
    localparam int RD_W_MAX = 8;

    typedef struct packed {
        logic [RD_W_MAX-1:0] rd;
        logic [31:0]         data;
        logic [2:0]          fmt;
        logic [1:0]          off;
    } wb_src_t;

    typedef struct packed {
        logic                we;
        logic [RD_W_MAX-1:0] rd;
        logic [31:0]         wdata;
    } wb_out_t;

    function automatic logic [31:0] wb_format(
        input logic [31:0] data,
        input logic [2:0]  fmt,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = off[1] ? data[31:16] : data[15:0];
        case (fmt)
            FMT_LB:  wb_format = {{24{b[7]}}, b};
            FMT_LH:  wb_format = {{16{h[15]}}, h};
            FMT_LBU: wb_format = {24'h00_0000, b};
            FMT_LHU: wb_format = {16'h0000, h};
            default: wb_format = data;
        endcase
    endfunction

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Request-to-one-hot grant, fixed priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int RR_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;

    // Scan from the start index, wrapping, and take the first requester.
    always_comb begin : p_search
        int start;
        int idx;
        start   = (RR_MODE != 0) ? int'(ptr_q) : 0;
        idx     = 0;
        w_pick  = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = start + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_i[idx]) begin
                w_found     = 1'b1;
                w_pick[idx] = 1'b1;
                w_win       = PTR_W'(idx);
            end
        end
    end

    assign gnt_o = (en_i && rst_n) ? w_pick : '0;

    always_comb begin : p_ptr_next
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_ptr_reg
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges NUM_SRC result producers onto one register-file port,
//               formats load data and registers the selected write.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int RR_MODE = 1,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    input  logic [NUM_SRC*3-1:0]      src_fmt,
    input  logic [NUM_SRC*2-1:0]      src_off,
    input  logic                      wb_stall,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [CNT_W-1:0]          contention_cnt
);

    wb_src_t          w_src [NUM_SRC];
    wb_src_t          w_sel;
    logic             w_any;
    logic [3:0]       w_nvalid;
    logic             w_multi;
    logic             w_unused_rd;
    wb_out_t          out_q;
    wb_out_t          out_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_src[i].rd   = RD_W_MAX'(src_rd[i*REG_AW +: REG_AW]);
        assign w_src[i].data = src_data[i*XLEN +: XLEN];
        assign w_src[i].fmt  = src_fmt[i*3 +: 3];
        assign w_src[i].off  = src_off[i*2 +: 2];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_SRC),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~wb_stall),
        .req_i (src_valid),
        .gnt_o (src_ready)
    );

    assign w_any = |src_ready;

    // Grant is one-hot, so an OR-reduction acts as the source mux.
    always_comb begin : p_select
        w_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                w_sel = w_sel | w_src[i];
            end
        end
    end

    always_comb begin : p_out_next
        out_d    = out_q;
        out_d.we = 1'b0;
        if (w_any) begin
            out_d.we    = (w_sel.rd != '0);
            out_d.rd    = w_sel.rd;
            out_d.wdata = wb_format(w_sel.data, w_sel.fmt, w_sel.off);
        end
    end

    always_comb begin : p_popcnt
        w_nvalid = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_nvalid = w_nvalid + {3'b000, src_valid[i]};
        end
        w_multi = (w_nvalid >= 4'd2);
    end

    always_comb begin : p_cnt_next
        cnt_d = cnt_q;
        if (w_multi && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign rf_we          = out_q.we;
    assign rf_rd          = out_q.rd[REG_AW-1:0];
    assign rf_wdata       = out_q.wdata;
    assign contention_cnt = cnt_q;
    assign w_unused_rd    = ^{1'b0, out_q.rd};

endmodule : wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Parametrised write-back stage that merges NUM_SRC result producers (ALU, LSU, mul/div, ...) onto the single register-file write port. It uses a valid/ready handshake per source and arbitrates one winner per cycle (fixed-priority or round-robin). It formats load data (byte/half/word, sign/zero extension) and registers the selected write. It sits between the execute/memory units and the register file, and also drives the forwarding network.

Parameters:
NUM_SRC, 3, number of write-back sources (2..8)
XLEN, 32, data width (fixed at 32 for load formatting)
REG_AW, 5, register address width
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
CNT_W, 16, width of contention counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  source i holds a result
src_ready  out  NUM_SRC  source i granted this cycle (combinational)
src_rd  in  NUM_SRC*REG_AW  destination register per source
src_data  in  NUM_SRC*XLEN  raw result per source (load data = aligned 32-bit word)
src_fmt  in  NUM_SRC*3  format code per source (funct3 encoding, 3'b111 = pass-through)
src_off  in  NUM_SRC*2  byte offset for load extraction
wb_stall  in  1  suppresses all grants this cycle
rf_we  out  1  register-file write enable (registered)
rf_rd  out  REG_AW  write address (registered)
rf_wdata  out  XLEN  write data (registered)
contention_cnt  out  CNT_W  saturating count of cycles with >1 valid source

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_rd=0, rf_wdata=0, rr pointer=0, contention_cnt=0. src_ready is low while reset is asserted.
- Handshake: transfer on src_valid[i] & src_ready[i].
  - Sources hold valid, rd, data, fmt and off stable until they are granted.
  - src_ready is at most one-hot.
  - src_ready is never asserted without the matching valid.
- Arbitration:
  - wb_stall=1 forces all src_ready=0.
  - RR_MODE=0: lowest-index valid source wins.
  - RR_MODE=1: search starts at the rr pointer and wraps modulo NUM_SRC. After a grant to source k, the pointer becomes (k+1) mod NUM_SRC. The pointer is unchanged on cycles with no grant.
- Formatting of the granted source:
  - 000 LB: sign-extend byte[off].
  - 001 LH: sign-extend half[off[1]]; off[0] ignored.
  - 010 LW: word; offset ignored.
  - 100 LBU: zero-extend byte[off].
  - 101 LHU: zero-extend half[off[1]].
  - 111, and reserved codes 011/110: data passes through unchanged.
- Output register, 1-cycle latency from grant:
  - On a grant: rf_we <= (rd != 0), rf_rd <= rd, rf_wdata <= formatted data.
  - On no grant: rf_we <= 0, and rf_rd/rf_wdata hold their values.
  - A grant to rd=x0 is still consumed (src_ready=1), but no write occurs.
- contention_cnt:
  - Increments on every cycle with popcount(src_valid) >= 2, regardless of wb_stall.
  - Saturates at all-ones and never wraps.
- Reset mid-operation: the pending output register is cleared and the write is lost. Producers re-present their results after reset; there is no replay inside the block.
- NUM_SRC=1: the arbiter degenerates to src_ready = src_valid & ~wb_stall.

Decomposition:
- wb_arbiter_pkg:
  - Format code localparams: FMT_LB, FMT_LH, FMT_LW, FMT_LBU, FMT_LHU, FMT_PASS.
  - wb_src_t struct: rd, data, fmt, off.
  - wb_out_t struct: we, rd, wdata.
- One natural sub-module, rr_arbiter: parametrised NUM_SRC request-to-one-hot grant with a fixed/round-robin mode and an internal pointer. Load formatting stays as a function in the package.

Test Plan:
- Reset: rst_n=0 mid-stream with src_valid=3'b111 -> rf_we=0, contention_cnt=0, src_ready=0 immediately; after release, first grant goes to src0.
- Fixed priority, RR_MODE=0: src_valid=3'b110 held for 2 cycles -> src1 granted both cycles; src2 is never granted until src1 deasserts.
- Round-robin, RR_MODE=1: all three sources valid continuously for 6 cycles -> grants 0,1,2,0,1,2; contention_cnt=6.
- Load formatting, fmt LB, off=2, data=32'h00_80_00_00, rd=5 -> next cycle rf_we=1, rf_rd=5, rf_wdata=32'hFFFF_FF80. Same input with LBU -> 32'h0000_0080. LH with off=3 -> upper half used, 32'h0000_0080.
- x0 and stall: valid rd=0 -> src_ready=1 but rf_we=0 next cycle. wb_stall=1 with src0 valid -> no ready and rf_we=0; on stall release, src0 is granted.
- Counter saturation: CNT_W=4, 20 contention cycles -> contention_cnt=4'hF held.
